// File: rtl/branch_predict_global.sv
// Gshare direction predictor: PHT indexed by PC ^ speculative GHR, prediction carried D->E->M,
// trained and checked in MEM, with a post-reset sweep that sets every counter to weak-not-taken.
module branch_predict_global #(
   parameter int PHT_DEPTH = 10
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stallD,
   input  logic        stallE,
   input  logic        stallM,
   input  logic        flushD,
   input  logic        flushE,
   input  logic        flushM,
   input  logic [31:0] pcF,
   input  logic        branchD,
   input  logic        pred_takeD,
   input  logic        branchM,
   input  logic        actual_takeM,
   input  logic        mispredictM,
   output logic        pred_globalD,
   output logic        global_errorM,
   output logic        ready
);

   localparam int PHT_SIZE = 2 ** PHT_DEPTH;

   typedef enum logic {S_INIT, S_RUN} state_t;

   state_t               state_q;
   logic [PHT_DEPTH-1:0] init_idx_q;
   logic                 ready_q;

   logic [PHT_DEPTH-1:0] ghr_spec_q, ghr_ret_q;
   logic [PHT_DEPTH-1:0] idx_f, idx_id_q, idx_ex_q, idx_mem_q;
   logic                 pred_f, pred_id_q, pred_ex_q, pred_mem_q;

   logic [1:0]           pht_q [PHT_SIZE];
   logic                 pht_we;
   logic [PHT_DEPTH-1:0] pht_waddr;
   logic [1:0]           pht_wdata, cnt_mem;

   logic                 unused_pc;

   assign unused_pc = ^{pcF[31:PHT_DEPTH+2], pcF[1:0]};

   assign idx_f   = pcF[PHT_DEPTH+1:2] ^ ghr_spec_q;
   assign pred_f  = ready_q & pht_q[idx_f][1];
   assign cnt_mem = pht_q[idx_mem_q];

   assign pred_globalD  = pred_id_q;
   assign global_errorM = branchM & (pred_mem_q != actual_takeM);
   assign ready         = ready_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_INIT;
         init_idx_q <= '0;
         ready_q    <= 1'b0;
      end else begin
         case (state_q)
            S_INIT: begin
               init_idx_q <= init_idx_q + PHT_DEPTH'(1);
               if (init_idx_q == {PHT_DEPTH{1'b1}}) begin
                  state_q <= S_RUN;
                  ready_q <= 1'b1;
               end
            end
            S_RUN: begin
               state_q <= S_RUN;
               ready_q <= 1'b1;
            end
            default: begin
               state_q    <= S_INIT;
               init_idx_q <= '0;
               ready_q    <= 1'b0;
            end
         endcase
      end
   end

   // Single write port: the sweep owns it during INIT, MEM training afterwards.
   always_comb begin
      pht_we    = 1'b0;
      pht_waddr = idx_mem_q;
      pht_wdata = cnt_mem;
      if (state_q == S_INIT) begin
         pht_we    = 1'b1;
         pht_waddr = init_idx_q;
         pht_wdata = 2'b01;
      end else if (branchM && !stallM && ready_q) begin
         pht_we = 1'b1;
         if (actual_takeM)
            pht_wdata = (cnt_mem == 2'b11) ? 2'b11 : cnt_mem + 2'b01;
         else
            pht_wdata = (cnt_mem == 2'b00) ? 2'b00 : cnt_mem - 2'b01;
      end
   end

   always_ff @(posedge clk) begin
      if (pht_we && !rst)
         pht_q[pht_waddr] <= pht_wdata;
   end

   always_ff @(posedge clk) begin
      if (rst || flushD) begin
         pred_id_q <= 1'b0;
         idx_id_q  <= '0;
      end else if (!stallD) begin
         pred_id_q <= pred_f;
         idx_id_q  <= idx_f;
      end

      if (rst || flushE) begin
         pred_ex_q <= 1'b0;
         idx_ex_q  <= '0;
      end else if (!stallE) begin
         pred_ex_q <= pred_id_q;
         idx_ex_q  <= idx_id_q;
      end

      if (rst || flushM) begin
         pred_mem_q <= 1'b0;
         idx_mem_q  <= '0;
      end else if (!stallM) begin
         pred_mem_q <= pred_ex_q;
         idx_mem_q  <= idx_ex_q;
      end
   end

   // Recovery rebuilds speculative history from the retired copy and beats any ID shift.
   always_ff @(posedge clk) begin
      if (rst) begin
         ghr_spec_q <= '0;
         ghr_ret_q  <= '0;
      end else if (ready_q) begin
         if (branchM && !stallM)
            ghr_ret_q <= {ghr_ret_q[PHT_DEPTH-2:0], actual_takeM};
         if (mispredictM)
            ghr_spec_q <= {ghr_ret_q[PHT_DEPTH-2:0], actual_takeM};
         else if (branchD && !stallD && !flushD)
            ghr_spec_q <= {ghr_spec_q[PHT_DEPTH-2:0], pred_takeD};
      end
   end

endmodule

// File: tb/tb_branch_predict_global.sv
// Scoreboard bench for branch_predict_global (PHT_DEPTH=4): directed stimulus queues
// expected values by target cycle; a negedge monitor pops and compares them.
module tb_branch_predict_global;

   localparam int D = 4;

   localparam int K_PRED  = 0;
   localparam int K_ERR   = 1;
   localparam int K_RDY   = 2;
   localparam int K_GSPEC = 3;
   localparam int K_GRET  = 4;
   localparam int K_PHT   = 5;
   localparam int K_EX    = 6;
   localparam int K_INIT  = 7;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stallD = 1'b0, stallE = 1'b0, stallM = 1'b0;
   logic        flushD = 1'b0, flushE = 1'b0, flushM = 1'b0;
   logic [31:0] pcF = 32'h40;
   logic        branchD = 1'b0, pred_takeD = 1'b0;
   logic        branchM = 1'b0, actual_takeM = 1'b0, mispredictM = 1'b0;
   logic        pred_globalD, global_errorM, ready;

   typedef struct {
      int         cyc;
      int         kind;
      int         sel;
      logic [7:0] exp;
      string      name;
   } exp_t;

   exp_t sb[$];
   int   tests = 0;
   int   fails = 0;
   int   cyc   = 0;

   branch_predict_global #(.PHT_DEPTH(D)) dut (
      .clk          (clk),
      .rst          (rst),
      .stallD       (stallD),
      .stallE       (stallE),
      .stallM       (stallM),
      .flushD       (flushD),
      .flushE       (flushE),
      .flushM       (flushM),
      .pcF          (pcF),
      .branchD      (branchD),
      .pred_takeD   (pred_takeD),
      .branchM      (branchM),
      .actual_takeM (actual_takeM),
      .mispredictM  (mispredictM),
      .pred_globalD (pred_globalD),
      .global_errorM(global_errorM),
      .ready        (ready)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic expect_at(input int c, input int kind, input int sel,
                            input logic [7:0] v, input string n);
      exp_t e;
      int   p;
      e.cyc = c; e.kind = kind; e.sel = sel; e.exp = v; e.name = n;
      p = sb.size();
      while (p > 0 && sb[p-1].cyc > c) p--;
      sb.insert(p, e);
   endtask

   function automatic logic [7:0] sample(input int kind, input int sel);
      logic [D-1:0] s;
      s = sel[D-1:0];
      case (kind)
         K_PRED:  return {7'b0, pred_globalD};
         K_ERR:   return {7'b0, global_errorM};
         K_RDY:   return {7'b0, ready};
         K_GSPEC: return {4'b0, dut.ghr_spec_q};
         K_GRET:  return {4'b0, dut.ghr_ret_q};
         K_PHT:   return {6'b0, dut.pht_q[s]};
         K_EX:    return {3'b0, dut.pred_ex_q, dut.idx_ex_q};
         K_INIT:  return {4'b0, dut.init_idx_q};
         default: return 8'hxx;
      endcase
   endfunction

   exp_t       cur;
   logic [7:0] act;

   always @(negedge clk) begin
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
         cur = sb.pop_front();
         act = sample(cur.kind, cur.sel);
         tests++;
         if (cur.cyc != cyc || act !== cur.exp) begin
            fails++;
            $display("FAIL %s @cyc%0d (checked at %0d): got %0h required %0h",
                     cur.name, cur.cyc, cyc, act, cur.exp);
         end else begin
            $display("[TB] ok %s @cyc%0d = %0h", cur.name, cyc, act);
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      // Reset and init sweep
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      expect_at(1,  K_RDY,  0, 8'h0, "ready_after_rst");
      expect_at(8,  K_PRED, 0, 8'h0, "pred_during_init");
      expect_at(16, K_RDY,  0, 8'h0, "ready_last_init");
      expect_at(17, K_RDY,  0, 8'h1, "ready_rises");
      for (int i = 0; i < 16; i++)
         expect_at(17, K_PHT, i, 8'h1, $sformatf("pht%0d_init", i));
      tick(16);

      // Training saturation at pc 0x40 (idx 0), error flag
      branchM = 1'b1; actual_takeM = 1'b1;
      expect_at(17, K_ERR,  0, 8'h1, "err_pred0_taken");
      expect_at(17, K_PRED, 0, 8'h0, "pred_first_run");
      expect_at(18, K_PRED, 0, 8'h0, "pred_weak_nt");
      expect_at(18, K_PHT,  0, 8'h2, "pht0_step1");
      tick(1);
      expect_at(18, K_ERR,  0, 8'h1, "err_pred0_taken2");
      expect_at(19, K_PHT,  0, 8'h3, "pht0_step2");
      expect_at(19, K_PRED, 0, 8'h1, "pred_after_weak_t");
      tick(1);
      expect_at(20, K_PHT,  0, 8'h3, "pht0_saturate");
      tick(1);
      branchM = 1'b0;
      expect_at(20, K_ERR,  0, 8'h0, "err_no_branch");
      tick(1);
      branchM = 1'b1; actual_takeM = 1'b1;
      expect_at(21, K_ERR,  0, 8'h0, "err_pred1_taken");
      expect_at(22, K_PHT,  0, 8'h3, "pht0_saturate2");
      expect_at(22, K_GRET, 0, 8'hF, "ghr_ret_shift");
      tick(1);

      // Stall D with a branch in ID: D held, no speculative shift
      branchM = 1'b0; actual_takeM = 1'b0;
      stallD = 1'b1; branchD = 1'b1; pred_takeD = 1'b1; pcF = 32'h44;
      expect_at(22, K_PRED, 0, 8'h1, "pred_before_stall");
      for (int k = 23; k <= 25; k++) begin
         expect_at(k, K_PRED,  0, 8'h1, "pred_held_stallD");
         expect_at(k, K_GSPEC, 0, 8'h0, "ghr_spec_no_shift_stall");
      end
      tick(3);
      stallD = 1'b0; branchD = 1'b0; pred_takeD = 1'b0;
      expect_at(26, K_PRED, 0, 8'h0,  "pred_idx1_after_stall");
      expect_at(26, K_EX,   0, 8'h10, "ex_reg_before_flush");
      tick(1);

      // Flush and stall E together: flush wins
      stallE = 1'b1; flushE = 1'b1;
      expect_at(27, K_EX,   0, 8'h00, "ex_reg_flush_over_stall");
      expect_at(27, K_PRED, 0, 8'h0,  "pred_idx1_again");
      tick(1);
      stallE = 1'b0; flushE = 1'b0; pcF = 32'h440;
      expect_at(28, K_PRED, 0, 8'h1,  "pred_alias_pc440");
      expect_at(28, K_EX,   0, 8'h01, "ex_reg_resumes");
      tick(1);

      // Reset from RUN, then reset mid-sweep at init_idx 7
      pcF = 32'h40; rst = 1'b1;
      expect_at(29, K_RDY,   0, 8'h0, "ready_rst_from_run");
      expect_at(29, K_GSPEC, 0, 8'h0, "ghr_spec_rst");
      expect_at(29, K_GRET,  0, 8'h0, "ghr_ret_rst");
      expect_at(29, K_PRED,  0, 8'h0, "pred_rst");
      tick(1);
      rst = 1'b0;
      expect_at(29, K_INIT, 0, 8'h0, "init_idx_start");
      expect_at(36, K_INIT, 0, 8'h7, "init_idx_7");
      expect_at(36, K_RDY,  0, 8'h0, "ready_mid_sweep");
      tick(7);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      expect_at(37, K_INIT, 0, 8'h0, "init_idx_restart");
      expect_at(38, K_INIT, 0, 8'h1, "init_idx_restart_step");
      expect_at(52, K_RDY,  0, 8'h0, "ready_restart_last_init");
      expect_at(53, K_RDY,  0, 8'h1, "ready_restart_rises");
      tick(16);

      // Speculative history then misprediction recovery
      branchD = 1'b1; pred_takeD = 1'b1;
      expect_at(54, K_GSPEC, 0, 8'h1, "ghr_spec_0001");
      tick(1);
      expect_at(55, K_GSPEC, 0, 8'h3, "ghr_spec_0011");
      tick(1);
      branchM = 1'b1; actual_takeM = 1'b0; mispredictM = 1'b1;
      expect_at(55, K_ERR,   0, 8'h0, "err_pred0_nt");
      expect_at(56, K_GSPEC, 0, 8'h0, "ghr_spec_recovered");
      expect_at(56, K_GRET,  0, 8'h0, "ghr_ret_after_nt");
      expect_at(56, K_PHT,   0, 8'h0, "pht0_decrement");
      tick(1);
      branchD = 1'b0; pred_takeD = 1'b0;
      branchM = 1'b0; mispredictM = 1'b0;
      tick(2);

      if (sb.size() != 0) begin
         tests++;
         fails++;
         $display("FAIL scoreboard_drain: got %0d pending required 0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
